// File: rtl/conv_pkg.sv
// Shared widths, FSM encoding and accumulator sizing
// for the streaming convolution engine.
package conv_pkg;

    localparam int DW = 8;
    localparam int PW = 16;
    localparam int FW = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_D,
        S_RUN,
        S_FLUSH
    } state_t;

    function automatic int acc_w(input int taps);
        return PW + $clog2(taps);
    endfunction

endpackage

// File: rtl/conv_window_mac.sv
// Combinational KxK signed multiply-accumulate over one window.
// Products are sign-extended to the accumulator width before summing.
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int K     = 3,
    parameter int ACC_W = acc_w(K * K)
) (
    input  logic [K*K*DW-1:0]       i_pix,
    input  logic [K*K*DW-1:0]       i_wgt,
    output logic signed [ACC_W-1:0] o_acc
);

    localparam int KK = K * K;

    logic signed [PW-1:0] w_prod [KK];

    for (genvar g = 0; g < KK; g++) begin : g_mul
        assign w_prod[g] = PW'($signed(i_pix[g*DW +: DW]))
                         * PW'($signed(i_wgt[g*DW +: DW]));
    end

    always_comb begin
        o_acc = '0;
        for (int i = 0; i < KK; i++) begin
            o_acc = o_acc + ACC_W'(w_prod[i]);
        end
    end

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming valid-conv engine: loads CH kernels and one image,
// then emits CH*OUT*OUT saturated results, one per cycle.
module conv_stream_engine
    import conv_pkg::*;
#(
    parameter int IMG   = 8,
    parameter int K     = 3,
    parameter int CH    = 3,
    parameter int SHIFT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          relu_en,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam int KK    = K * K;
    localparam int OUT   = IMG - K + 1;
    localparam int NW    = CH * KK;
    localparam int NP    = IMG * IMG;
    localparam int NMAX  = (NW > NP) ? NW : NP;
    localparam int LD_W  = $clog2(NMAX);
    localparam int WA_W  = $clog2(NW);
    localparam int PA_W  = $clog2(NP);
    localparam int OW    = $clog2(OUT + 1);
    localparam int CHW   = $clog2(CH + 1);
    localparam int ACC_W = acc_w(KK);
    localparam int EXT_W = (ACC_W > SHIFT + FW) ? ACC_W : SHIFT + FW;

    localparam logic signed [FW-1:0] SAT_HI = FW'(127);
    localparam logic signed [FW-1:0] SAT_LO = FW'(-128);

    state_t                    r_state;
    state_t                    w_next;
    logic [LD_W-1:0]           r_ld_cnt;
    logic [CHW-1:0]            r_ch;
    logic [OW-1:0]             r_r;
    logic [OW-1:0]             r_c;
    logic                      r_relu;
    logic                      r_out_valid;
    logic                      r_out_last;
    logic                      r_done;
    logic [DW-1:0]             r_out_data;
    logic [DW-1:0]             r_wmem [NW];
    logic [DW-1:0]             r_pmem [NP];

    logic                      w_in_fire;
    logic                      w_ld_last;
    logic                      w_start_ok;
    logic                      w_run_load;
    logic                      w_out_fire;
    logic                      w_win_last;
    logic [KK*DW-1:0]          w_pix;
    logic [KK*DW-1:0]          w_wgt;
    logic signed [ACC_W-1:0]   w_acc;
    logic signed [EXT_W-1:0]   w_ext;
    logic signed [FW-1:0]      w_field;
    logic [DW-1:0]             w_res;

    assign in_ready  = (r_state == S_LOAD_W) || (r_state == S_LOAD_D);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_start_ok = (r_state == S_IDLE) && start && !r_done;
    assign w_run_load = (r_state == S_RUN) && (!r_out_valid || out_ready);
    assign w_ld_last  = (r_state == S_LOAD_W) ? (r_ld_cnt == LD_W'(NW - 1))
                                              : (r_ld_cnt == LD_W'(NP - 1));
    assign w_win_last = (r_ch == CHW'(CH - 1)) && (r_r == OW'(OUT - 1))
                     && (r_c == OW'(OUT - 1));

    always_comb begin
        w_pix = '0;
        w_wgt = '0;
        for (int kr = 0; kr < K; kr++) begin
            for (int kc = 0; kc < K; kc++) begin
                w_pix[(kr*K + kc)*DW +: DW] =
                    r_pmem[PA_W'((int'(r_r) + kr) * IMG + int'(r_c) + kc)];
                w_wgt[(kr*K + kc)*DW +: DW] =
                    r_wmem[WA_W'(int'(r_ch) * KK + kr * K + kc)];
            end
        end
    end

    conv_window_mac #(
        .K     (K),
        .ACC_W (ACC_W)
    ) u_mac (
        .i_pix (w_pix),
        .i_wgt (w_wgt),
        .o_acc (w_acc)
    );

    assign w_ext   = EXT_W'(w_acc);
    assign w_field = w_ext[SHIFT +: FW];

    always_comb begin
        w_res = w_field[DW-1:0];
        if (r_relu && w_field[FW-1]) begin
            w_res = '0;
        end else if (w_field > SAT_HI) begin
            w_res = {1'b0, {(DW-1){1'b1}}};
        end else if (w_field < SAT_LO) begin
            w_res = {1'b1, {(DW-1){1'b0}}};
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_start_ok) w_next = S_LOAD_W;
            S_LOAD_W: if (w_in_fire && w_ld_last) w_next = S_LOAD_D;
            S_LOAD_D: if (w_in_fire && w_ld_last) w_next = S_RUN;
            S_RUN:    if (w_run_load && w_win_last) w_next = S_FLUSH;
            S_FLUSH:  if (w_out_fire) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Storage is never cleared; a frame always overwrites it before use.
    always_ff @(posedge clk) begin
        if (w_in_fire && r_state == S_LOAD_W) r_wmem[r_ld_cnt[WA_W-1:0]] <= in_data;
        if (w_in_fire && r_state == S_LOAD_D) r_pmem[r_ld_cnt[PA_W-1:0]] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ld_cnt    <= '0;
            r_ch        <= '0;
            r_r         <= '0;
            r_c         <= '0;
            r_relu      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_out_fire && (r_state == S_FLUSH);
            if (w_start_ok) r_relu <= relu_en;
            if (w_in_fire) r_ld_cnt <= w_ld_last ? '0 : r_ld_cnt + 1'b1;
            if (w_run_load) begin
                r_out_data  <= w_res;
                r_out_valid <= 1'b1;
                r_out_last  <= w_win_last;
                // Channel wraps on the last window so no address overruns.
                if (r_c == OW'(OUT - 1)) begin
                    r_c <= '0;
                    if (r_r == OW'(OUT - 1)) begin
                        r_r  <= '0;
                        r_ch <= w_win_last ? '0 : r_ch + 1'b1;
                    end else begin
                        r_r <= r_r + 1'b1;
                    end
                end else begin
                    r_c <= r_c + 1'b1;
                end
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Scoreboard bench for conv_stream_engine: directed frames push
// expected results; a monitor pops and compares on each handshake.
module tb_conv_stream_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       relu_en;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    conv_stream_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } exp_t;

    exp_t       q[$];
    int         vectors  = 0;
    int         errors   = 0;
    int         done_cnt = 0;
    int         hs_frame = 0;
    bit         done_exp = 1'b0;
    int         bp_mode  = 0;
    int         bp_phase = 0;
    int         bp_stall = 0;
    logic [7:0] tb_w [27];
    logic [7:0] tb_p [64];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every cycle with out_valid must show the queue head;
    // this also proves data stays put while stalled.
    always @(negedge clk) begin
        if (done_exp) begin
            done_exp = 1'b0;
            check("done_pulse", {31'd0, done}, 1);
            check("busy_fall", {31'd0, busy}, 0);
        end
        if (done) done_cnt++;
        if (out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out", {31'd0, out_valid}, 0);
            end else begin
                check("out_data", {24'd0, out_data}, {24'd0, q[0].d});
                check("out_last", {31'd0, out_last}, {31'd0, q[0].last});
                if (out_ready) begin
                    if (q[0].last) done_exp = 1'b1;
                    void'(q.pop_front());
                    hs_frame++;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (bp_mode == 0) begin
            out_ready = 1'b1;
        end else if (bp_phase == 0) begin
            out_ready = 1'b1;
            if (hs_frame >= 20) begin
                bp_phase = 1;
                bp_stall = 10;
            end
        end else if (bp_phase == 1) begin
            out_ready = 1'b0;
            bp_stall  = bp_stall - 1;
            if (bp_stall == 0) bp_phase = 2;
        end else begin
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (n == 200) check("in_ready_timeout", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) break;
        end
        if (n == 3000) begin
            check("frame_timeout_q", q.size(), 0);
            check("frame_timeout_busy", {31'd0, busy}, 0);
        end
    endtask

    task automatic fill(input int pv, input int w0, input int w1, input int w2);
        for (int i = 0; i < 64; i++) tb_p[i] = 8'(pv);
        for (int i = 0; i < 9; i++) begin
            tb_w[i]      = 8'(w0);
            tb_w[9 + i]  = 8'(w1);
            tb_w[18 + i] = 8'(w2);
        end
    endtask

    task automatic push_uniform(input int v0, input int v1, input int v2);
        exp_t e;
        int   v;
        for (int ch = 0; ch < 3; ch++) begin
            v = (ch == 0) ? v0 : (ch == 1) ? v1 : v2;
            for (int i = 0; i < 36; i++) begin
                e.d    = 8'(v);
                e.last = (ch == 2 && i == 35);
                q.push_back(e);
            end
        end
    endtask

    // Pixel(r,c) = 8r+c; window sum = 9*(8r+c+9), so a weight of
    // 16*m gives m*144*(8r+c+9) before the >>8 field select.
    task automatic push_ramp();
        exp_t e;
        int   m;
        int   v;
        for (int i = 0; i < 64; i++) tb_p[i] = 8'(i);
        for (int i = 0; i < 9; i++) begin
            tb_w[i]      = 8'(16);
            tb_w[9 + i]  = 8'(32);
            tb_w[18 + i] = 8'(-16);
        end
        for (int ch = 0; ch < 3; ch++) begin
            m = (ch == 0) ? 1 : (ch == 1) ? 2 : -1;
            for (int r = 0; r < 6; r++) begin
                for (int c = 0; c < 6; c++) begin
                    v      = (m * 144 * (8 * r + c + 9)) >>> 8;
                    e.d    = 8'(v);
                    e.last = (ch == 2 && r == 5 && c == 5);
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic run_frame(input bit relu, input bit late);
        int d0;
        d0       = done_cnt;
        hs_frame = 0;
        @(posedge clk);
        #1;
        start   = 1'b1;
        relu_en = relu;
        @(posedge clk);
        #1;
        start   = 1'b0;
        relu_en = 1'b0;
        for (int i = 0; i < 27; i++) send(tb_w[i]);
        for (int i = 0; i < 64; i++) send(tb_p[i]);
        if (late) begin
            @(posedge clk);
            #1;
            start    = 1'b1;
            relu_en  = 1'b1;
            in_valid = 1'b1;
            @(negedge clk);
            check("in_ready_run", {31'd0, in_ready}, 0);
            @(posedge clk);
            #1;
            start   = 1'b0;
            relu_en = 1'b0;
        end
        wait_idle();
        if (late) check("in_ready_idle", {31'd0, in_ready}, 0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("done_count", done_cnt - d0, 1);
        if (late) check("late_start_ignored", {31'd0, busy}, 0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        relu_en  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_last", {31'd0, out_last}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_out_data", {24'd0, out_data}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        fill(16, 16, 16, 16);
        push_uniform(9, 9, 9);
        run_frame(1'b0, 1'b0);

        fill(16, 16, -16, 16);
        push_uniform(9, -9, 9);
        run_frame(1'b0, 1'b0);

        push_uniform(9, 0, 9);
        run_frame(1'b1, 1'b0);

        fill(127, 127, 127, 127);
        push_uniform(127, 127, 127);
        run_frame(1'b0, 1'b0);

        fill(-128, 127, 127, 127);
        push_uniform(-128, -128, -128);
        run_frame(1'b0, 1'b0);

        push_ramp();
        bp_phase = 0;
        bp_mode  = 1;
        run_frame(1'b0, 1'b0);
        bp_mode  = 0;

        fill(16, 16, 16, 16);
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 27; i++) send(tb_w[i]);
        for (int i = 0; i < 20; i++) send(tb_p[i]);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_ready", {31'd0, in_ready}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_out_valid", {31'd0, out_valid}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_uniform(9, 9, 9);
        run_frame(1'b0, 1'b0);

        fill(16, 16, -16, 16);
        push_uniform(9, -9, 9);
        run_frame(1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
